// File: rtl/counter_updown_param_if.sv
// Control and status bundle for counter_updown_param.
// The master drives the count controls; the slave (the counter) returns count and flags.
interface counter_updown_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              inc;
  logic              dec;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              flags_clr;

  logic [WIDTH-1:0]  cnt;
  logic              zero;
  logic              at_max;
  logic              ovf;
  logic              unf;
  logic              ovf_sticky;
  logic              unf_sticky;

  modport master (
    output clr, load, load_val, inc, dec, step, limit, flags_clr,
    input  cnt, zero, at_max, ovf, unf, ovf_sticky, unf_sticky
  );

  modport slave (
    input  clr, load, load_val, inc, dec, step, limit, flags_clr,
    output cnt, zero, at_max, ovf, unf, ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with programmable limit, wrap or saturate behaviour,
// overflow/underflow pulses and sticky flags.
module counter_updown_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int SAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  counter_updown_param_if.slave bus
);

  localparam int SW = WIDTH + 2;

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             ovf_sticky_reg, ovf_sticky_next;
  logic             unf_sticky_reg, unf_sticky_next;

  logic [WIDTH-1:0] step_w;
  logic [SW-1:0]    cnt_x, step_x, limit_x, sum_x;
  logic             up, down, over;
  logic [WIDTH-1:0] load_clip, wrap_up, wrap_dn;

  assign step_w  = WIDTH'(bus.step);
  assign cnt_x   = SW'(cnt_reg);
  assign step_x  = SW'(bus.step);
  assign limit_x = SW'(bus.limit);
  assign sum_x   = cnt_x + step_x;

  assign over = (cnt_reg > bus.limit);
  assign up   = bus.inc & ~bus.dec & (bus.step != '0);
  assign down = bus.dec & ~bus.inc & (bus.step != '0);

  // Wrapped results only need the low WIDTH bits; modular arithmetic gives the same bits
  // as the wide form s - (limit+1) and cnt + (limit+1) - step.
  assign load_clip = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
  assign wrap_up   = cnt_reg + step_w - bus.limit - WIDTH'(1);
  assign wrap_dn   = cnt_reg + bus.limit + WIDTH'(1) - step_w;

  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (bus.clr) begin
      cnt_next = '0;
    end else if (bus.load) begin
      cnt_next = load_clip;
    end else if (over) begin
      cnt_next = bus.limit;
    end else if (up) begin
      if (sum_x <= limit_x) begin
        cnt_next = cnt_reg + step_w;
      end else begin
        ovf_next = 1'b1;
        cnt_next = (SAT != 0) ? bus.limit : wrap_up;
      end
    end else if (down) begin
      if (step_x <= cnt_x) begin
        cnt_next = cnt_reg - step_w;
      end else begin
        unf_next = 1'b1;
        cnt_next = (SAT != 0) ? '0 : wrap_dn;
      end
    end
  end

  // Sticky flags follow the registered pulses, so they rise one cycle after them;
  // a pulse coinciding with flags_clr keeps the flag set.
  always_comb begin
    ovf_sticky_next = ovf_reg | (ovf_sticky_reg & ~bus.flags_clr);
    unf_sticky_next = unf_reg | (unf_sticky_reg & ~bus.flags_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      ovf_reg        <= 1'b0;
      unf_reg        <= 1'b0;
      ovf_sticky_reg <= 1'b0;
      unf_sticky_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      ovf_reg        <= ovf_next;
      unf_reg        <= unf_next;
      ovf_sticky_reg <= ovf_sticky_next;
      unf_sticky_reg <= unf_sticky_next;
    end
  end

  assign bus.cnt        = cnt_reg;
  assign bus.zero       = (cnt_reg == '0);
  assign bus.at_max     = (cnt_reg == bus.limit);
  assign bus.ovf        = ovf_reg;
  assign bus.unf        = unf_reg;
  assign bus.ovf_sticky = ovf_sticky_reg;
  assign bus.unf_sticky = unf_sticky_reg;

`ifdef ASSERTS_SV
  logic rst_seen_reg;
  logic step_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) rst_seen_reg <= 1'b1;
  end

  assign step_bad = (SAT == 0) && (bus.inc || bus.dec) && (step_x > limit_x + SW'(1));

  a_cnt_known: assert property (@(posedge clk)
    (rst_seen_reg === 1'b1) |-> !$isunknown(cnt_reg));

  a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    !step_bad |=> (cnt_reg <= $past(bus.limit)));

  a_inc_dec_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.inc && bus.dec && !bus.clr && !bus.load && !over) |=> $stable(cnt_reg));

  a_ovf_unf_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(ovf_reg && unf_reg));

  a_step_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !step_bad);
`endif

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: a wrap (SAT=0) and a saturate (SAT=1) instance share
// the same stimulus; checked by a vector table, hand sequences and a random run.
module tb_counter_updown_param;

  logic       clk;
  logic       rst_n;
  logic       clr, load, inc, dec, flags_clr;
  logic [7:0] load_val, limit;
  logic [3:0] step;

  int n_tests = 0;
  int n_fail  = 0;

  // model state, index 0 = wrap instance, 1 = saturate instance
  int m_cnt[2], m_ovf[2], m_unf[2], m_ost[2], m_ust[2];

  counter_updown_param_if #(.WIDTH(8), .STEP_W(4)) bus_w ();
  counter_updown_param_if #(.WIDTH(8), .STEP_W(4)) bus_s ();

  assign bus_w.clr = clr;        assign bus_s.clr = clr;
  assign bus_w.load = load;      assign bus_s.load = load;
  assign bus_w.load_val = load_val; assign bus_s.load_val = load_val;
  assign bus_w.inc = inc;        assign bus_s.inc = inc;
  assign bus_w.dec = dec;        assign bus_s.dec = dec;
  assign bus_w.step = step;      assign bus_s.step = step;
  assign bus_w.limit = limit;    assign bus_s.limit = limit;
  assign bus_w.flags_clr = flags_clr; assign bus_s.flags_clr = flags_clr;

  counter_updown_param #(.WIDTH(8), .STEP_W(4), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w));
  counter_updown_param #(.WIDTH(8), .STEP_W(4), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, clr, load;
    logic [7:0] lv;
    logic       inc, dec;
    logic [3:0] step;
    logic [7:0] lim;
    logic       fclr;
    logic [7:0] ecw;
    logic [1:0] efw;   // {ovf, unf}
    logic [7:0] ecs;
    logic [1:0] efs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int r, input int c, input int l, input int lv, input int i,
                     input int d, input int st, input int lim, input int fc,
                     input int ecw, input int efw, input int ecs, input int efs);
    vec_t v;
    v.rst_n = 1'(r);  v.clr = 1'(c);  v.load = 1'(l);  v.lv = 8'(lv);
    v.inc = 1'(i);    v.dec = 1'(d);  v.step = 4'(st); v.lim = 8'(lim);
    v.fclr = 1'(fc);  v.ecw = 8'(ecw); v.efw = 2'(efw); v.ecs = 8'(ecs); v.efs = 2'(efs);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the counting rules expressed with plain integer modulo arithmetic.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int c, nc, o, u, lim, stp;
      lim = int'(limit); stp = int'(step); c = m_cnt[k]; nc = c; o = 0; u = 0;
      if (!rst_n) begin
        m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_ost[k] = 0; m_ust[k] = 0;
        continue;
      end
      m_ost[k] = (m_ovf[k] != 0 || (m_ost[k] != 0 && !flags_clr)) ? 1 : 0;
      m_ust[k] = (m_unf[k] != 0 || (m_ust[k] != 0 && !flags_clr)) ? 1 : 0;
      if (clr) nc = 0;
      else if (load) nc = (int'(load_val) < lim) ? int'(load_val) : lim;
      else if (c > lim) nc = lim;
      else if (inc != dec && stp != 0) begin
        if (inc) begin
          if (c + stp > lim) begin o = 1; nc = (k == 1) ? lim : (c + stp) % (lim + 1); end
          else nc = c + stp;
        end else begin
          if (stp > c) begin u = 1; nc = (k == 1) ? 0 : (c - stp + lim + 1) % (lim + 1); end
          else nc = c - stp;
        end
      end
      m_cnt[k] = nc; m_ovf[k] = o; m_unf[k] = u;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s w.cnt", tag), 32'(bus_w.cnt), m_cnt[0]);
    check($sformatf("%s w.ovf", tag), 32'(bus_w.ovf), m_ovf[0]);
    check($sformatf("%s w.unf", tag), 32'(bus_w.unf), m_unf[0]);
    check($sformatf("%s w.ovf_sticky", tag), 32'(bus_w.ovf_sticky), m_ost[0]);
    check($sformatf("%s w.unf_sticky", tag), 32'(bus_w.unf_sticky), m_ust[0]);
    check($sformatf("%s w.zero", tag), 32'(bus_w.zero), (m_cnt[0] == 0) ? 1 : 0);
    check($sformatf("%s w.at_max", tag), 32'(bus_w.at_max), (m_cnt[0] == int'(limit)) ? 1 : 0);
    check($sformatf("%s s.cnt", tag), 32'(bus_s.cnt), m_cnt[1]);
    check($sformatf("%s s.ovf", tag), 32'(bus_s.ovf), m_ovf[1]);
    check($sformatf("%s s.unf", tag), 32'(bus_s.unf), m_unf[1]);
    check($sformatf("%s s.ovf_sticky", tag), 32'(bus_s.ovf_sticky), m_ost[1]);
    check($sformatf("%s s.unf_sticky", tag), 32'(bus_s.unf_sticky), m_ust[1]);
    check($sformatf("%s s.zero", tag), 32'(bus_s.zero), (m_cnt[1] == 0) ? 1 : 0);
    check($sformatf("%s s.at_max", tag), 32'(bus_s.at_max), (m_cnt[1] == int'(limit)) ? 1 : 0);
  endtask

  task automatic idle();
    clr = 0; load = 0; inc = 0; dec = 0; flags_clr = 0; rst_n = 1;
  endtask

  initial begin
    idle(); rst_n = 0; load_val = 0; step = 0; limit = 9;

    // ---------------- vector table ----------------
    //   rst clr ld  lv  inc dec st  lim fclr  ecw efw ecs efs
    add(0, 0, 0, 0,   0, 0, 0,  9,  0,   0,  0,  0,  0);
    add(0, 0, 0, 0,   0, 0, 0,  9,  0,   0,  0,  0,  0);
    add(1, 0, 1, 8,   0, 0, 0,  9,  0,   8,  0,  8,  0);
    add(1, 0, 0, 0,   1, 0, 3,  9,  0,   1,  2,  9,  2);
    add(1, 0, 0, 0,   0, 0, 3,  9,  0,   1,  0,  9,  0);
    add(1, 0, 0, 0,   0, 1, 5,  9,  0,   6,  1,  4,  0);
    add(1, 0, 0, 0,   0, 1, 5,  9,  0,   1,  0,  0,  1);
    add(1, 0, 1, 2,   0, 0, 0,  200, 0,  2,  0,  2,  0);
    add(1, 0, 0, 0,   0, 1, 5,  200, 0,  198, 1, 0,  1);
    add(1, 0, 0, 0,   0, 1, 5,  200, 0,  193, 0, 0,  1);
    add(1, 1, 1, 7,   1, 0, 5,  200, 0,  0,  0,  0,  0);
    add(1, 0, 1, 250, 0, 0, 0,  100, 0,  100, 0, 100, 0);
    add(1, 0, 0, 0,   1, 1, 4,  100, 0,  100, 0, 100, 0);
    add(1, 0, 0, 0,   1, 0, 0,  100, 0,  100, 0, 100, 0);
    add(1, 0, 0, 0,   0, 0, 0,  20,  0,  20,  0, 20,  0);
    add(1, 0, 0, 0,   1, 0, 1,  20,  0,  0,   2, 20,  2);
    add(0, 0, 1, 5,   0, 0, 0,  20,  0,  0,   0, 0,   0);
    add(1, 0, 0, 0,   1, 0, 15, 20,  0,  15,  0, 15,  0);
    add(1, 0, 0, 0,   1, 0, 15, 20,  0,  9,   2, 20,  2);
    add(1, 0, 0, 0,   0, 0, 0,  0,   0,  0,   0, 0,   0);
    add(1, 0, 0, 0,   1, 0, 1,  0,   0,  0,   2, 0,   2);
    add(1, 0, 0, 0,   0, 1, 1,  255, 0,  255, 1, 0,   1);
    add(1, 0, 0, 0,   1, 0, 1,  255, 0,  0,   2, 1,   0);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; clr = tbl[i].clr; load = tbl[i].load; load_val = tbl[i].lv;
      inc = tbl[i].inc; dec = tbl[i].dec; step = tbl[i].step; limit = tbl[i].lim;
      flags_clr = tbl[i].fclr;
      tick();
      check($sformatf("vec%0d w.cnt", i), 32'(bus_w.cnt), 32'(tbl[i].ecw));
      check($sformatf("vec%0d w.flags", i), 32'({bus_w.ovf, bus_w.unf}), 32'(tbl[i].efw));
      check($sformatf("vec%0d s.cnt", i), 32'(bus_s.cnt), 32'(tbl[i].ecs));
      check($sformatf("vec%0d s.flags", i), 32'({bus_s.ovf, bus_s.unf}), 32'(tbl[i].efs));
      check($sformatf("vec%0d w.zero", i), 32'(bus_w.zero), (tbl[i].ecw == 0) ? 1 : 0);
      check($sformatf("vec%0d w.at_max", i), 32'(bus_w.at_max), (tbl[i].ecw == tbl[i].lim) ? 1 : 0);
      $display("[TB] vec%0d w.cnt=%0d s.cnt=%0d", i, bus_w.cnt, bus_s.cnt);
    end

    // ---------------- reset and hold ----------------
    idle(); rst_n = 0; limit = 9; tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold w.cnt", 32'(bus_w.cnt), 0);
      check("hold w.zero", 32'(bus_w.zero), 1);
      check("hold flags", 32'({bus_w.ovf, bus_w.unf, bus_w.ovf_sticky, bus_w.unf_sticky}), 0);
    end
    $display("[TB] reset/hold done");

    // ---------------- sticky timing ----------------
    load = 1; load_val = 8; tick(); idle();
    inc = 1; step = 3; tick(); idle();
    check("stk pulse ovf", 32'(bus_w.ovf), 1);
    check("stk pulse cnt", 32'(bus_w.cnt), 1);
    check("stk not yet", 32'(bus_w.ovf_sticky), 0);
    tick();
    check("stk ovf gone", 32'(bus_w.ovf), 0);
    check("stk set", 32'(bus_w.ovf_sticky), 1);
    tick(); tick();
    check("stk held", 32'(bus_w.ovf_sticky), 1);
    flags_clr = 1; tick(); idle();
    check("stk cleared", 32'(bus_w.ovf_sticky), 0);
    load = 1; load_val = 9; tick(); idle();
    inc = 1; step = 2; tick(); idle();
    flags_clr = 1; tick(); idle();
    check("stk set wins", 32'(bus_w.ovf_sticky), 1);
    check_all("stk");
    $display("[TB] sticky sequence done");

    // ---------------- simultaneous inc/dec ----------------
    limit = 100; load = 1; load_val = 50; tick(); idle();
    inc = 1; dec = 1; step = 4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("incdec w.cnt", 32'(bus_w.cnt), 50);
      check("incdec s.cnt", 32'(bus_s.cnt), 50);
    end
    dec = 0; step = 0; tick(); idle();
    check("step0 w.cnt", 32'(bus_w.cnt), 50);
    $display("[TB] inc/dec hold done");

    // ---------------- limit shrink, mid-run reset ----------------
    load = 1; load_val = 60; tick(); idle();
    limit = 20; tick();
    check("shrink cnt", 32'(bus_w.cnt), 20);
    check("shrink ovf", 32'(bus_w.ovf), 0);
    check("shrink at_max", 32'(bus_w.at_max), 1);
    inc = 1; step = 5; tick(); idle(); tick();
    check("pre-rst sticky", 32'(bus_s.ovf_sticky), 1);
    rst_n = 0; load = 1; load_val = 5; tick(); idle();
    check("rst cnt", 32'(bus_w.cnt), 0);
    check("rst sticky", 32'({bus_w.ovf_sticky, bus_s.ovf_sticky}), 0);
    check_all("rst");
    $display("[TB] shrink/reset done");

    // ---------------- randomized run ----------------
    for (int i = 0; i < 3000; i++) begin
      int maxs;
      rst_n = ($urandom_range(0, 63) != 0);
      clr = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom);
      inc = 1'($urandom);
      dec = 1'($urandom);
      flags_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0)
        limit = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      maxs = (int'(limit) + 1 < 15) ? int'(limit) + 1 : 15;
      step = 4'($urandom_range(0, maxs));
      tick();
      check_all($sformatf("rnd%0d", i));
    end
    $display("[TB] random run done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
